// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with leading-zero blanking and a dead cycle per digit.
// Optional SEG7_BLINK_EN adds blink_in/BLINK_FRAMES per-digit blinking driven by a frame counter.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_in,
`endif
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       pc_q, pc_d;
  logic [DW-1:0]       di_q, di_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_q, frame_d;
  logic                wrap;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1011000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    pc_d  = pc_q + 1'b1;
    di_d  = di_q;
    wrap  = 1'b0;
    bcd_d = load ? bcd_in : bcd_q;
    dp_d  = load ? dp_in : dp_q;
    if (pc_q == PW'(PRESCALE - 1)) begin
      pc_d = '0;
      if (di_q == DW'(DIGITS - 1)) begin
        di_d = '0;
        wrap = 1'b1;
      end else begin
        di_d = di_q + 1'b1;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fc_q, fc_d;
  logic          phase_q, phase_d;

  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fc_q == FW'(BLINK_FRAMES - 1)) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
    end
  end
`endif

  logic [DIGITS-1:0] lz;
  logic              run;
  logic [3:0]        nib;
  logic              dp_sel;
  logic              lz_sel;
  logic              hide;

  always_comb begin
    lz     = '0;
    run    = 1'b1;
    nib    = '0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    hide   = 1'b0;
    // lz[j] is set when digit j and every digit above it are zero
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run & (bcd_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      lz[DIGITS-1-k] = run;
    end
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (di_q == DW'(k)) begin
        nib    = bcd_q[4*k +: 4];
        dp_sel = dp_q[k];
        lz_sel = lz[k];
`ifdef SEG7_BLINK_EN
        hide   = phase_q & blink_in[k];
`endif
      end
    end
    seg_d   = '1;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    frame_d = wrap;
    if (pc_q != '0) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        an_n_d[k] = (di_q != DW'(k));
      end
      seg_d  = (lzb && (di_q != '0) && lz_sel) ? 7'b1111111 : decode(nib);
      dp_n_d = ~dp_sel;
      if (hide) begin
        seg_d  = '1;
        dp_n_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      di_q    <= '0;
      bcd_q   <= '0;
      dp_q    <= '0;
      seg_q   <= '1;
      dp_n_q  <= 1'b1;
      an_n_q  <= '1;
      frame_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      di_q    <= di_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
      an_n_q  <= an_n_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIGITS=4, PRESCALE=4.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb = 1'b0;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_in = '0;
`endif
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in), .lzb(lzb),
`ifdef SEG7_BLINK_EN
    .blink_in(blink_in),
`endif
    .seg(seg), .dp_n(dp_n), .an_n(an_n), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_pc, m_di;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [6:0]  dec [16];
  logic [7:0]  seen [4];
  int          frame_cnt, dp_good, dp_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_di = 0; m_bcd = '0; m_dp = '0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) seen[i] = 8'hFF;
    frame_cnt = 0; dp_good = 0; dp_bad = 0;
  endtask

  task automatic tick();
    exp_t e;
    logic [3:0] nib;
    @(posedge clk);
    e = '{seg: 7'h7F, dp_n: 1'b1, an_n: 4'hF, frame: 1'b0};
    if (m_pc != 0) begin
      e.an_n[m_di] = 1'b0;
      nib = m_bcd[4*m_di +: 4];
      e.seg = (lzb && m_di > 0 && (m_bcd >> (4*m_di)) == 16'd0) ? 7'h7F : dec[nib];
      e.dp_n = ~m_dp[m_di];
    end
    e.frame = (m_pc == 3 && m_di == 3);
    sb.push_back(e);
    if (load) begin m_bcd = bcd_in; m_dp = dp_in; end
    if (m_pc == 3) begin m_pc = 0; m_di = (m_di + 1) % 4; end
    else m_pc++;
    @(negedge clk);
    e = sb.pop_front();
    check("seg", 32'(seg), 32'(e.seg));
    check("dp_n", 32'(dp_n), 32'(e.dp_n));
    check("an_n", 32'(an_n), 32'(e.an_n));
    check("frame", 32'(frame), 32'(e.frame));
    for (int d = 0; d < 4; d++)
      if (an_n == ~(4'b0001 << d)) seen[d] = {1'b0, seg};
    if (frame) frame_cnt++;
    if (!dp_n) begin
      if (an_n == 4'b1011) dp_good++;
      else dp_bad++;
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic z);
    bcd_in = b; dp_in = d; lzb = z; load = 1'b1;
    tick();
    load = 1'b0; bcd_in = $urandom;
    clear_obs();
  endtask

  task automatic check_seen(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    check({tag, "_d3"}, 32'(seen[3]), 32'(s3));
    check({tag, "_d2"}, 32'(seen[2]), 32'(s2));
    check({tag, "_d1"}, 32'(seen[1]), 32'(s1));
    check({tag, "_d0"}, 32'(seen[0]), 32'(s0));
  endtask

  initial begin
    logic [3:0] an_seq [6];
    int guard;
    dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
            7'h7F, 7'h7F};
    an_seq = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_frame", 32'(frame), 32'h0);
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      tick();
      check("start_an_n", 32'(an_n), 32'(an_seq[i]));
    end

    do_load(16'h1234, 4'b0000, 1'b0);
    repeat (32) tick();
    check("frame_cnt", 32'(frame_cnt), 32'd2);
    check_seen("h1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

    do_load(16'h0070, 4'b0000, 1'b1);
    repeat (20) tick();
    check_seen("h0070", 7'h7F, 7'h7F, 7'b1011000, 7'b1000000);

    do_load(16'h0000, 4'b0000, 1'b1);
    repeat (20) tick();
    check_seen("h0000", 7'h7F, 7'h7F, 7'h7F, 7'b1000000);

    do_load(16'h0A00, 4'b0100, 1'b0);
    repeat (20) tick();
    check("nibA_d2", 32'(seen[2]), 32'h7F);
    check("dp_lit_d2", 32'(dp_good > 0), 32'd1);
    check("dp_other", 32'(dp_bad), 32'd0);

    do_load(16'h5678, 4'b0000, 1'b0);
    guard = 0;
    while (!(m_di == 2 && m_pc == 2) && guard < 32) begin
      tick();
      guard++;
    end
    check("reach_d2", 32'(guard < 32), 32'd1);
    check("mid_an_n", 32'(an_n), 32'b1011);
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp_n", 32'(dp_n), 32'h1);
    check("async_an_n", 32'(an_n), 32'hF);
    check("async_frame", 32'(frame), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    check("resume_dead", 32'(an_n), 32'hF);
    tick();
    check("resume_d0", 32'(an_n), 32'b1110);
    check("resume_seg", 32'(seg), 32'(7'b1000000));

    for (int r = 0; r < 8; r++) begin
      do_load(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat (12) tick();
      lzb = ~lzb;
      repeat (12) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
